ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Two-master arbiter/sequencer in front of the single-clock 8x256 data RAM.
//  Shares the RAM between master 0 (instruction fetch) and master 1 (load/store unit).
//  Accepts one request per access slot, drives the RAM write/read strobes and
//  returns read data to the owning master with a valid pulse.
// PARAMETERS
//  addr_size  8  RAM address width (RAM depth = 2**addr_size)
//  data_size  8  RAM data width
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  rst          in   1          synchronous, active-high reset
//  m0_req       in   1          master 0 request; addr/we/wdata held stable until m0_gnt
//  m0_we        in   1          1 = write, 0 = read
//  m0_addr      in   addr_size  access address
//  m0_wdata     in   data_size  write data
//  m0_gnt       out  1          request accepted this cycle (combinational)
//  m0_rvalid    out  1          m0_rdata valid, one-cycle pulse
//  m0_rdata     out  data_size  read data
//  m1_*         same set as m0_* for master 1
//  ram_wr_en    out  1          to RAM write enable
//  ram_wr_addr  out  addr_size  to RAM write address
//  ram_wdata    out  data_size  to RAM write data
//  ram_rd_en    out  1          to RAM read enable
//  ram_rd_addr  out  addr_size  to RAM read address
//  ram_rdata    in   data_size  from RAM registered read data (1-cycle latency)
//  busy         out  1          1 while state = RD_WAIT
// BEHAVIOUR
//  - States: IDLE, RD_WAIT. Reset -> IDLE, owner = 0, last_grant = 1.
//  - Reset outputs: all gnt/rvalid/ram_wr_en/ram_rd_en/busy = 0; rdata buses = 0.
//  - gnt, ram_* strobes and addresses are combinational from state + req; they are
//    forced to 0 while rst = 1.
//  - IDLE: if a req is high, select a winner (see CONFIGURATION); assert its gnt.
//    Winner we=1: ram_wr_en=1, ram_wr_addr/ram_wdata = winner's; stay IDLE (1 cycle).
//    Winner we=0: ram_rd_en=1, ram_rd_addr = winner's; owner <= winner; -> RD_WAIT.
//  - RD_WAIT: no grants, all gnt = 0. m<owner>_rvalid = 1, m<owner>_rdata = ram_rdata;
//    other master's rvalid = 0. -> IDLE next cycle.
//  - Read latency: gnt in cycle N -> rvalid/rdata in cycle N+1. Max throughput: 1 write
//    per cycle, 1 read per 2 cycles.
//  - Non-owner rdata holds last value (registered copy); owner rdata = ram_rdata.
//  - Simultaneous req: exactly one gnt per cycle; loser keeps req, served later.
//  - Never asserts ram_wr_en and ram_rd_en in the same cycle.
//  - Address/data widths pass through unchanged; no wrap-around logic (RAM indexes).
//  - rst during RD_WAIT: -> IDLE, pending rvalid dropped (no pulse), owner cleared.
// CONFIGURATION
//  RAM_ARB_ROUND_ROBIN_EN defined: round-robin; on a collision, grant the master
//    not in last_grant; last_grant <= winner on every grant.
//  Not defined: fixed priority, master 0 always wins; last_grant register not built.
//  Single-requester behaviour identical in both builds.
// TESTING
//  1. m1 write addr 0x10 data 0xA5, then m1 read 0x10 -> m1_gnt both; m1_rvalid with 0xA5
//     one cycle after read gnt; busy = 1 that cycle.
//  2. m0 and m1 read together (0x01, 0x02) -> m0 gnt first, then m1 two cycles later;
//     each rvalid only to its owner with correct data.
//  3. Both hold write req 4 cycles: RR build -> gnt m0,m1,m0,m1; fixed build -> m0 x4.
//  4. m0 read gnt, rst asserted in RD_WAIT -> no m0_rvalid, state IDLE, all strobes 0.
//  5. m1 write 0x3C to 0xFF while m0 req idle -> ram_wr_en 1 cycle, ram_rd_en never
//     asserted; read back 0xFF returns 0x3C.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter/sequencer in front of a single-clock data RAM.
// Master 0 is instruction fetch and master 1 is the load/store unit.
// One request is accepted per access slot. A write takes one cycle. A read takes
// two cycles: the grant cycle, then a RD_WAIT cycle in which the RAM's registered
// read data is returned to the owning master together with a one-cycle rvalid pulse.
//
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN
//   defined     : round-robin arbitration on collisions (last_grant register built)
//   not defined : fixed priority, master 0 always wins
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mX_req/we/addr/wdata           master X request, held stable until mX_gnt
//   mX_gnt                         request accepted this cycle (combinational)
//   mX_rvalid/rdata                read data return to master X
//   ram_wr_en/wr_addr/wdata        RAM write port
//   ram_rd_en/rd_addr              RAM read port
//   ram_rdata                      RAM read data, one cycle after ram_rd_en
//   busy                           high while a read is being returned
module ram_arbiter #(
  parameter int unsigned addr_size = 8,
  parameter int unsigned data_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [addr_size-1:0] m0_addr,
  input  logic [data_size-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [data_size-1:0] m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [addr_size-1:0] m1_addr,
  input  logic [data_size-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [data_size-1:0] m1_rdata,
  output logic                 ram_wr_en,
  output logic [addr_size-1:0] ram_wr_addr,
  output logic [data_size-1:0] ram_wdata,
  output logic                 ram_rd_en,
  output logic [addr_size-1:0] ram_rd_addr,
  input  logic [data_size-1:0] ram_rdata,
  output logic                 busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   w_owner_nxt;
  logic   w_win;   // 0 = master 0, 1 = master 1
  logic   w_any_req;
  logic   w_we;
  logic [addr_size-1:0] w_addr;
  logic [data_size-1:0] w_wdata;
  logic [data_size-1:0] r_m0_rdata;
  logic [data_size-1:0] r_m1_rdata;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;
  logic w_last_grant_nxt;
`endif

  // Winner selection; only meaningful when a request is present.
  always_comb begin
    w_any_req = m0_req | m1_req;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (m0_req && m1_req) begin
      w_win = ~r_last_grant;
    end else begin
      w_win = m1_req;
    end
`else
    w_win = ~m0_req;
`endif
    w_we    = w_win ? m1_we    : m0_we;
    w_addr  = w_win ? m1_addr  : m0_addr;
    w_wdata = w_win ? m1_wdata : m0_wdata;
  end

  // Next-state and combinational outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    w_last_grant_nxt = r_last_grant;
`endif
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    m0_rdata    = r_m0_rdata;
    m1_rdata    = r_m1_rdata;
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wdata   = '0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    busy        = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          m0_gnt = ~w_win;
          m1_gnt = w_win;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          w_last_grant_nxt = w_win;
`endif
          if (w_we) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = w_addr;
            ram_wdata   = w_wdata;
          end else begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = w_addr;
            w_owner_nxt = w_win;
            w_state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        busy        = 1'b1;
        w_state_nxt = IDLE;
        if (r_owner) begin
          m1_rvalid = 1'b1;
          m1_rdata  = ram_rdata;
        end else begin
          m0_rvalid = 1'b1;
          m0_rdata  = ram_rdata;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Reset masks everything visible, including a pending read return.
    if (rst) begin
      m0_gnt      = 1'b0;
      m1_gnt      = 1'b0;
      m0_rvalid   = 1'b0;
      m1_rvalid   = 1'b0;
      m0_rdata    = '0;
      m1_rdata    = '0;
      ram_wr_en   = 1'b0;
      ram_wr_addr = '0;
      ram_wdata   = '0;
      ram_rd_en   = 1'b0;
      ram_rd_addr = '0;
      busy        = 1'b0;
    end
  end

  // State, owner and held read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      r_last_grant <= w_last_grant_nxt;
`endif
      // Keep a copy so a master's rdata holds once it stops being the owner.
      if (r_state == RD_WAIT) begin
        if (r_owner) begin
          r_m1_rdata <= ram_rdata;
        end else begin
          r_m0_rdata <= ram_rdata;
        end
      end
    end
  end

endmodule
